// File: rtl/lane_deser_pkg.sv
// lane_deser_pkg: shared constants and helpers for the lane deserializer.
// Provides lane-ordering selectors, lane index mapping and beat parity.
package lane_deser_pkg;

   localparam int ORDER_LSB_FIRST = 0;
   localparam int ORDER_MSB_FIRST = 1;

   // Widest beat the parity helper accepts; callers zero-extend.
   localparam int PAR_MAX_W = 64;

   function automatic int lane_index(
      input int cnt,
      input int lanes,
      input int order
   );
      if (order == ORDER_MSB_FIRST) begin
         return lanes - 1 - cnt;
      end
      return cnt;
   endfunction

   // Even-parity bit: the value that makes data plus bit hold an even
   // number of ones. Zero-extension does not change it.
   function automatic logic even_parity(
      input logic [PAR_MAX_W-1:0] data
   );
      return ^data;
   endfunction

endpackage

// File: rtl/lane_deser_slot.sv
// lane_deser_slot: one lane of the accumulator (data register + keep bit).
// Ports: clk, rst_n, load_i, clear_i, data_i -> data_o, keep_o.
module lane_deser_slot
   import lane_deser_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clear_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] data_o,
   output logic         keep_o
);

   logic [W-1:0] data_q;
   logic         keep_q;

   // Clear wins: the completing beat is forwarded to the output
   // register directly, so the slot only needs to empty itself.
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         data_q <= '0;
         keep_q <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         keep_q <= 1'b1;
      end
   end

   assign data_o = data_q;
   assign keep_o = keep_q;

endmodule

// File: rtl/lane_deserializer.sv
// lane_deserializer: packs LANE_W-bit beats into a LANES-lane word.
// Ports: clk, rst_n; s_valid/s_ready/s_data/s_last/s_parity in;
// m_valid/m_ready/m_data/m_keep/m_last/m_par_err out.
module lane_deserializer
   import lane_deser_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int LANE_W    = 8,
   parameter int PARITY_EN = 0,
   parameter int ORDER     = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [LANE_W-1:0]       s_data,
   input  logic                    s_last,
   input  logic                    s_parity,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [LANES*LANE_W-1:0] m_data,
   output logic [LANES-1:0]        m_keep,
   output logic                    m_last,
   output logic                    m_par_err
);

   localparam int DW = LANES * LANE_W;
   localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

   logic             accept;
   logic             done;
   logic             beat_err;
   logic [DW-1:0]    word_d;
   logic [LANES-1:0] keep_d;

   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic [DW-1:0]    data_q, data_d;
   logic [LANES-1:0] keep_q, keep_nx;
   logic             last_q, last_d;
   logic             perr_q, perr_d;

   assign s_ready = rst_n && (!valid_q || m_ready);
   assign accept  = s_valid && s_ready;

   if (PARITY_EN != 0) begin : g_par
      assign beat_err = s_parity ^ even_parity(PAR_MAX_W'(s_data));
   end else begin : g_nopar
      logic unused_par;
      assign unused_par = s_parity;
      assign beat_err   = 1'b0;
   end

   if (LANES == 1) begin : g_pass
      assign done   = accept;
      assign word_d = s_data;
      assign keep_d = 1'b1;
   end else begin : g_acc
      logic [CW-1:0]    cnt_q, cnt_d;
      logic [CW-1:0]    lane;
      logic [LANES-1:0] load;
      logic [DW-1:0]    slot_q;
      logic [LANES-1:0] slot_keep;

      assign done = accept &&
                    (s_last || cnt_q == CW'(LANES - 1));

      case (ORDER)
         ORDER_MSB_FIRST: begin : g_msb
            assign lane = CW'(lane_index(int'(cnt_q), LANES,
                                         ORDER_MSB_FIRST));
         end
         default: begin : g_lsb
            assign lane = CW'(lane_index(int'(cnt_q), LANES,
                                         ORDER_LSB_FIRST));
         end
      endcase

      for (genvar j = 0; j < LANES; j++) begin : g_lane
         assign load[j] = accept && (lane == CW'(j));

         lane_deser_slot #(
            .W(LANE_W)
         ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[j]),
            .clear_i (done),
            .data_i  (s_data),
            .data_o  (slot_q[j*LANE_W +: LANE_W]),
            .keep_o  (slot_keep[j])
         );

         // Completing beat bypasses its slot straight into the word.
         assign word_d[j*LANE_W +: LANE_W] =
            load[j] ? s_data : slot_q[j*LANE_W +: LANE_W];
         assign keep_d[j] = load[j] | slot_keep[j];
      end

      always_comb begin
         cnt_d = cnt_q;
         if (done) begin
            cnt_d = '0;
         end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
   end

   always_comb begin
      err_d   = err_q;
      valid_d = valid_q;
      data_d  = data_q;
      keep_nx = keep_q;
      last_d  = last_q;
      perr_d  = perr_q;
      if (done) begin
         err_d   = 1'b0;
         valid_d = 1'b1;
         data_d  = word_d;
         keep_nx = keep_d;
         last_d  = s_last;
         perr_d  = err_q | beat_err;
      end else begin
         if (accept) begin
            err_d = err_q | beat_err;
         end
         if (valid_q && m_ready) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         err_q   <= err_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         keep_q  <= keep_nx;
         last_q  <= last_d;
         perr_q  <= perr_d;
      end
   end

   assign m_valid   = valid_q;
   assign m_data    = data_q;
   assign m_keep    = keep_q;
   assign m_last    = last_q;
   assign m_par_err = perr_q;

endmodule

// File: tb/tb_lane_deserializer.sv
// tb_lane_deserializer: directed and randomized checks of lane_deserializer.
// Instances: A (LSB-first, no parity), B (MSB-first, parity), C (one lane).
module tb_lane_deserializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       s_valid, s_last, s_parity, m_ready;
   logic [7:0] s_data;

   logic        a_s_ready, a_m_valid, a_m_last, a_m_perr;
   logic [31:0] a_m_data;
   logic [3:0]  a_m_keep;
   logic        b_s_ready, b_m_valid, b_m_last, b_m_perr;
   logic [31:0] b_m_data;
   logic [3:0]  b_m_keep;

   logic       c_s_valid, c_s_last, c_s_parity, c_m_ready;
   logic [7:0] c_s_data;
   logic       c_s_ready, c_m_valid, c_m_last, c_m_perr;
   logic [7:0] c_m_data;
   logic [0:0] c_m_keep;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] ad;
      logic [31:0] bd;
      logic [3:0]  ak;
      logic [3:0]  bk;
      logic        last;
      logic        perr;
   } ab_word_t;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       perr;
   } c_word_t;

   lane_deserializer #(
      .LANES(4), .LANE_W(8), .PARITY_EN(0), .ORDER(0)
   ) u_a (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
      .s_last(s_last), .s_parity(s_parity),
      .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
      .m_keep(a_m_keep), .m_last(a_m_last), .m_par_err(a_m_perr)
   );

   lane_deserializer #(
      .LANES(4), .LANE_W(8), .PARITY_EN(1), .ORDER(1)
   ) u_b (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
      .s_last(s_last), .s_parity(s_parity),
      .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
      .m_keep(b_m_keep), .m_last(b_m_last), .m_par_err(b_m_perr)
   );

   lane_deserializer #(
      .LANES(1), .LANE_W(8), .PARITY_EN(1), .ORDER(0)
   ) u_c (
      .clk(clk), .rst_n(rst_n),
      .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
      .s_last(c_s_last), .s_parity(c_s_parity),
      .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
      .m_keep(c_m_keep), .m_last(c_m_last), .m_par_err(c_m_perr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic last,
                       input logic bad);
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = last;
      s_parity = (^d) ^ bad;
      tick();
   endtask

   task automatic idle();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      s_valid   = 1'b1;
      c_s_valid = 1'b1;
      m_ready   = 1'b1;
      c_m_ready = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({a_m_valid, a_m_last, a_m_perr} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 000",
                  {a_m_valid, a_m_last, a_m_perr});
      end
      n_checks++;
      if ({a_m_data, a_m_keep} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_word: got %h/%b want 0/0",
                  a_m_data, a_m_keep);
      end
      n_checks++;
      if ({a_s_ready, b_s_ready, c_s_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 000",
                  {a_s_ready, b_s_ready, c_s_ready});
      end
      n_checks++;
      if ({c_m_valid, c_m_keep, c_m_data} !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_c: got %b/%b/%h want 0/0/0",
                  c_m_valid, c_m_keep, c_m_data);
      end
      idle();
      c_s_valid = 1'b0;
      rst_n     = 1'b1;
      tick();
      n_checks++;
      if (a_m_valid !== 1'b0 || c_m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_word: got %b/%b want 0/0",
                  a_m_valid, c_m_valid);
      end
   endtask

   task automatic test_lsb_word();
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         n_checks++;
         if (a_m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_early_valid: beat %0d got %b want 0",
                     i, a_m_valid);
         end
         beat(8'(i * 8'h11), 1'b0, 1'b0);
      end
      n_checks++;
      if ({a_m_valid, a_m_data, a_m_keep, a_m_last, a_m_perr} !==
          {1'b1, 32'h44332211, 4'hf, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL lsb_word: got v%b %h k%b l%b p%b want v1 44332211 k1111 l0 p0",
                  a_m_valid, a_m_data, a_m_keep, a_m_last, a_m_perr);
      end
      n_checks++;
      if ({b_m_valid, b_m_data, b_m_keep, b_m_perr} !==
          {1'b1, 32'h11223344, 4'hf, 1'b0}) begin
         n_fail++;
         $display("FAIL msb_full_word: got v%b %h k%b p%b want v1 11223344 k1111 p0",
                  b_m_valid, b_m_data, b_m_keep, b_m_perr);
      end
      idle();
      tick();
      n_checks++;
      if (a_m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL lsb_one_cycle: got %b want 0", a_m_valid);
      end
   endtask

   task automatic test_msb_last();
      m_ready = 1'b1;
      beat(8'hAA, 1'b0, 1'b0);
      beat(8'hBB, 1'b1, 1'b0);
      n_checks++;
      if ({b_m_valid, b_m_data, b_m_keep, b_m_last} !==
          {1'b1, 32'hAABB0000, 4'b1100, 1'b1}) begin
         n_fail++;
         $display("FAIL msb_last: got v%b %h k%b l%b want v1 aabb0000 k1100 l1",
                  b_m_valid, b_m_data, b_m_keep, b_m_last);
      end
      n_checks++;
      if ({a_m_data, a_m_keep, a_m_last} !==
          {32'h0000BBAA, 4'b0011, 1'b1}) begin
         n_fail++;
         $display("FAIL lsb_last: got %h k%b l%b want 0000bbaa k0011 l1",
                  a_m_data, a_m_keep, a_m_last);
      end
      idle();
      tick();
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      for (int i = 1; i <= 4; i++) beat(8'(i), 1'b0, 1'b0);
      s_valid  = 1'b1;
      s_data   = 8'h55;
      s_last   = 1'b0;
      s_parity = ^s_data;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if (a_s_ready !== 1'b0 || b_s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready: cycle %0d got %b/%b want 0/0",
                     i, a_s_ready, b_s_ready);
         end
         tick();
         n_checks++;
         if ({a_m_valid, a_m_data, a_m_keep} !==
             {1'b1, 32'h04030201, 4'hf}) begin
            n_fail++;
            $display("FAIL bp_hold: cycle %0d got v%b %h k%b want v1 04030201 k1111",
                     i, a_m_valid, a_m_data, a_m_keep);
         end
      end
      m_ready = 1'b1;
      tick();
      n_checks++;
      if (a_m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got %b want 0", a_m_valid);
      end
      beat(8'h66, 1'b0, 1'b0);
      beat(8'h77, 1'b0, 1'b0);
      beat(8'h88, 1'b0, 1'b0);
      n_checks++;
      if ({a_m_valid, a_m_data, a_m_keep, b_m_data} !==
          {1'b1, 32'h88776655, 4'hf, 32'h55667788}) begin
         n_fail++;
         $display("FAIL bp_next_word: got v%b %h k%b b%h want v1 88776655 k1111 b55667788",
                  a_m_valid, a_m_data, a_m_keep, b_m_data);
      end
      idle();
      tick();
   endtask

   task automatic test_parity();
      m_ready = 1'b1;
      beat(8'h01, 1'b0, 1'b1);
      beat(8'h02, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b0);
      beat(8'h04, 1'b0, 1'b0);
      n_checks++;
      if ({b_m_valid, b_m_perr, a_m_perr, b_m_data} !==
          {1'b1, 1'b1, 1'b0, 32'h01020304}) begin
         n_fail++;
         $display("FAIL parity_bad: got v%b pb%b pa%b %h want v1 pb1 pa0 01020304",
                  b_m_valid, b_m_perr, a_m_perr, b_m_data);
      end
      for (int i = 0; i < 4; i++) beat(8'(8'h10 + i), 1'b0, 1'b0);
      n_checks++;
      if ({b_m_valid, b_m_perr} !== 2'b10) begin
         n_fail++;
         $display("FAIL parity_clean: got v%b p%b want v1 p0",
                  b_m_valid, b_m_perr);
      end
      idle();
      tick();
   endtask

   task automatic test_reset_midword();
      m_ready = 1'b1;
      beat(8'h91, 1'b0, 1'b0);
      beat(8'h92, 1'b0, 1'b0);
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++;
      if (a_m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_valid: got %b want 0", a_m_valid);
      end
      for (int i = 1; i <= 4; i++) beat(8'(8'hA0 + i), 1'b0, 1'b0);
      n_checks++;
      if ({a_m_valid, a_m_data, a_m_keep, b_m_data} !==
          {1'b1, 32'hA4A3A2A1, 4'hf, 32'hA1A2A3A4}) begin
         n_fail++;
         $display("FAIL midreset_word: got v%b %h k%b b%h want v1 a4a3a2a1 k1111 ba1a2a3a4",
                  a_m_valid, a_m_data, a_m_keep, b_m_data);
      end
      idle();
      tick();
   endtask

   task automatic test_random_ab();
      ab_word_t   exp_q[$];
      logic [7:0] cur[$];
      logic       cur_bad;
      logic       bad;
      ab_word_t   w;
      cur_bad = 1'b0;
      for (int cyc = 0; cyc < 310; cyc++) begin
         bad = 1'b0;
         if (cyc < 300) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            s_last  = ($urandom_range(0, 5) == 0);
            bad     = ($urandom_range(0, 7) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
         end else if (cyc == 300) begin
            s_valid = 1'b1;
            s_data  = 8'($urandom);
            s_last  = 1'b1;
            m_ready = 1'b1;
         end else begin
            idle();
            m_ready = 1'b1;
         end
         s_parity = (^s_data) ^ bad;
         #1;
         n_checks++;
         if (a_s_ready !== (!a_m_valid || m_ready)) begin
            n_fail++;
            $display("FAIL rnd_ready: cyc %0d got %b want %b",
                     cyc, a_s_ready, !a_m_valid || m_ready);
         end
         if (a_m_valid === 1'b1 && m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rnd_extra: cyc %0d got word %h want none",
                        cyc, a_m_data);
            end else begin
               w = exp_q.pop_front();
               if ({a_m_data, a_m_keep, a_m_last, a_m_perr,
                    b_m_data, b_m_keep, b_m_last, b_m_perr} !==
                   {w.ad, w.ak, w.last, 1'b0,
                    w.bd, w.bk, w.last, w.perr}) begin
                  n_fail++;
                  $display("FAIL rnd_word: cyc %0d got %h k%b l%b p%b / %h k%b l%b p%b want %h k%b l%b p0 / %h k%b l%b p%b",
                           cyc, a_m_data, a_m_keep, a_m_last, a_m_perr,
                           b_m_data, b_m_keep, b_m_last, b_m_perr,
                           w.ad, w.ak, w.last, w.bd, w.bk, w.last, w.perr);
               end
            end
         end
         if (s_valid && a_s_ready) begin
            cur.push_back(s_data);
            cur_bad |= bad;
            if (cur.size() == 4 || s_last) begin
               w = '0;
               for (int k = 0; k < cur.size(); k++) begin
                  w.ad |= 32'(cur[k]) << (8 * k);
                  w.bd |= 32'(cur[k]) << (8 * (3 - k));
                  w.ak[k]     = 1'b1;
                  w.bk[3 - k] = 1'b1;
               end
               w.last  = s_last;
               w.perr  = cur_bad;
               exp_q.push_back(w);
               cur.delete();
               cur_bad = 1'b0;
            end
         end
         tick();
      end
      n_checks++;
      if (exp_q.size() != 0 || a_m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rnd_drain: got %0d pending, valid %b want 0, 0",
                  exp_q.size(), a_m_valid);
      end
   endtask

   task automatic test_random_lanes1();
      c_word_t exp_q[$];
      c_word_t w;
      logic    bad;
      for (int cyc = 0; cyc < 210; cyc++) begin
         bad = 1'b0;
         if (cyc < 200) begin
            c_s_valid = ($urandom_range(0, 3) != 0);
            c_s_data  = 8'($urandom);
            c_s_last  = ($urandom_range(0, 1) == 0);
            bad       = ($urandom_range(0, 5) == 0);
            c_m_ready = ($urandom_range(0, 2) != 0);
         end else begin
            c_s_valid = 1'b0;
            c_s_last  = 1'b0;
            c_m_ready = 1'b1;
         end
         c_s_parity = (^c_s_data) ^ bad;
         #1;
         if (c_m_valid === 1'b1 && c_m_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL l1_extra: cyc %0d got %h want none",
                        cyc, c_m_data);
            end else begin
               w = exp_q.pop_front();
               if ({c_m_data, c_m_keep, c_m_last, c_m_perr} !==
                   {w.data, 1'b1, w.last, w.perr}) begin
                  n_fail++;
                  $display("FAIL l1_word: cyc %0d got %h k%b l%b p%b want %h k1 l%b p%b",
                           cyc, c_m_data, c_m_keep, c_m_last, c_m_perr,
                           w.data, w.last, w.perr);
               end
            end
         end
         if (c_s_valid && c_s_ready) begin
            w.data = c_s_data;
            w.last = c_s_last;
            w.perr = bad;
            exp_q.push_back(w);
         end
         tick();
      end
      n_checks++;
      if (exp_q.size() != 0 || c_m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL l1_drain: got %0d pending, valid %b want 0, 0",
                  exp_q.size(), c_m_valid);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'h00;
      s_last     = 1'b0;
      s_parity   = 1'b0;
      m_ready    = 1'b1;
      c_s_valid  = 1'b0;
      c_s_data   = 8'h00;
      c_s_last   = 1'b0;
      c_s_parity = 1'b0;
      c_m_ready  = 1'b1;
      test_reset();
      test_lsb_word();
      test_msb_last();
      test_backpressure();
      test_parity();
      test_reset_midword();
      test_random_ab();
      test_random_lanes1();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
